crossing_ctrl: RTL and testbench

Pedestrian-crossing controller that sits directly upstream of the road traffic light and drives its `go` input. It debounces a raw crossing push-button and latches a crossing request. Once the road has had a minimum green period, it drops `go` and waits out a clearance interval so the light can finish its stopping sequence. It then asserts a walk signal for a fixed time and returns the road to go.

---
 rtl/crossing_ctrl.sv | 145 ++++++++++++++
 tb/tb_crossing_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossing_ctrl.sv
// Pedestrian-crossing controller: synchronizes and debounces a push-button,
// latches a crossing request, and sequences the road light through
// GO -> CLEAR -> WALK -> GO. The road light's go input is driven from here.
module crossing_ctrl #(
    parameter int DEBOUNCE = 4,
    parameter int MIN_GO   = 8,
    parameter int CLEAR    = 6,
    parameter int WALK     = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic go,
    output logic walk,
    output logic req_pending
);

    localparam int DB_W    = $clog2(DEBOUNCE);
    localparam int GO_W    = (MIN_GO > 1) ? $clog2(MIN_GO) : 1;
    localparam int TMR_MAX = (CLEAR > WALK) ? CLEAR : WALK;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [GO_W-1:0]  GO_LAST   = GO_W'(MIN_GO - 1);
    localparam logic [TMR_W-1:0] CLR_LAST  = TMR_W'(CLEAR - 1);
    localparam logic [TMR_W-1:0] WALK_LAST = TMR_W'(WALK - 1);

    typedef enum logic [1:0] {
        S_GO    = 2'd0,
        S_CLEAR = 2'd1,
        S_WALK  = 2'd2
    } state_t;

    // Button path registers
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             press;

    // Sequencer registers
    state_t           state_q, state_d;
    logic [GO_W-1:0]  go_cnt_q, go_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             req_q, req_d;
    logic             go_q, go_d;
    logic             walk_q, walk_d;

    // Synchronize the raw button and accept a level change only after
    // DEBOUNCE consecutive samples disagree with the accepted level.
    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = ~stable_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press = ~stable_q & stable_d;
    end

    // Next-state logic: request latching, phase timers and output decode.
    // A press only registers while the road is in GO; presses seen during
    // CLEAR or WALK are dropped rather than queued.
    always_comb begin
        state_d  = state_q;
        go_cnt_d = go_cnt_q;
        tmr_d    = tmr_q;
        req_d    = req_q;
        if (press && (state_q == S_GO)) begin
            req_d = 1'b1;
        end
        case (state_q)
            S_GO: begin
                if (req_q && (go_cnt_q == GO_LAST)) begin
                    state_d = S_CLEAR;
                    tmr_d   = '0;
                end else if (go_cnt_q != GO_LAST) begin
                    go_cnt_d = go_cnt_q + 1'b1;
                end
            end
            S_CLEAR: begin
                if (tmr_q == CLR_LAST) begin
                    state_d = S_WALK;
                    tmr_d   = '0;
                    req_d   = 1'b0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_WALK: begin
                if (tmr_q == WALK_LAST) begin
                    state_d  = S_GO;
                    go_cnt_d = '0;
                    tmr_d    = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d  = S_GO;
                go_cnt_d = '0;
                tmr_d    = '0;
            end
        endcase
        go_d   = (state_d == S_GO);
        walk_d = (state_d == S_WALK);
    end

    // State and output registers with synchronous reset back to idle GO.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
            state_q  <= S_GO;
            go_cnt_q <= '0;
            tmr_q    <= '0;
            req_q    <= 1'b0;
            go_q     <= 1'b1;
            walk_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            go_cnt_q <= go_cnt_d;
            tmr_q    <= tmr_d;
            req_q    <= req_d;
            go_q     <= go_d;
            walk_q   <= walk_d;
        end
    end

    assign go          = go_q;
    assign walk        = walk_q;
    assign req_pending = req_q;

endmodule

// File: tb/tb_crossing_ctrl.sv
// Testbench for crossing_ctrl: directed timing scenarios with literal
// expectations plus a randomized run, all continuously compared against a
// phase/elapsed-time model of the crossing sequence.
module tb_crossing_ctrl;

    localparam int DEBOUNCE = 4;
    localparam int MIN_GO   = 8;
    localparam int CLEAR    = 6;
    localparam int WALK     = 10;

    localparam int P_GO    = 0;
    localparam int P_CLEAR = 1;
    localparam int P_WALK  = 2;

    logic clk;
    logic rst;
    logic btn;
    logic go;
    logic walk;
    logic req_pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    int   m_phase;
    int   m_t;
    logic m_req;
    logic m_stable;
    logic raw_q[$];
    logic win_q[$];

    crossing_ctrl #(
        .DEBOUNCE(DEBOUNCE),
        .MIN_GO  (MIN_GO),
        .CLEAR   (CLEAR),
        .WALK    (WALK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .go         (go),
        .walk       (walk),
        .req_pending(req_pending)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge given the sampled inputs.
    task automatic model_step(input logic r, input logic b);
        logic sync_v;
        logic rose;
        logic old_req;
        int   old_phase;
        bit   all_diff;
        if (r) begin
            m_phase  = P_GO;
            m_t      = 0;
            m_req    = 1'b0;
            m_stable = 1'b0;
            raw_q    = '{1'b0, 1'b0};
            win_q.delete();
            return;
        end
        // Button seen by the debouncer lags the raw pin by two edges.
        sync_v = raw_q.pop_front();
        raw_q.push_back(b);
        // Accept a level change when the last DEBOUNCE samples all disagree.
        win_q.push_back(sync_v);
        if (win_q.size() > DEBOUNCE) void'(win_q.pop_front());
        all_diff = (win_q.size() == DEBOUNCE);
        foreach (win_q[j]) if (win_q[j] == m_stable) all_diff = 0;
        rose = 1'b0;
        if (all_diff) begin
            m_stable = ~m_stable;
            rose     = m_stable;
            win_q.delete();
        end
        old_req   = m_req;
        old_phase = m_phase;
        if (rose && (old_phase == P_GO)) m_req = 1'b1;
        case (old_phase)
            P_GO: begin
                if (old_req && (m_t >= MIN_GO - 1)) begin
                    m_phase = P_CLEAR;
                    m_t     = 0;
                end else m_t++;
            end
            P_CLEAR: begin
                if (m_t == CLEAR - 1) begin
                    m_phase = P_WALK;
                    m_t     = 0;
                    m_req   = 1'b0;
                end else m_t++;
            end
            default: begin
                if (m_t == WALK - 1) begin
                    m_phase = P_GO;
                    m_t     = 0;
                end else m_t++;
            end
        endcase
    endtask

    // Compare process: sample inputs at the edge, check outputs mid-cycle.
    initial begin
        logic s_rst;
        logic s_btn;
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_btn = btn;
            @(negedge clk);
            model_step(s_rst, s_btn);
            chk("model_go", go, (m_phase == P_GO));
            chk("model_walk", walk, (m_phase == P_WALK));
            chk("model_req", req_pending, m_req);
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a reset edge e: release reset, press from e+1.
    task automatic fresh_press();
        rst = 1'b0;
        btn = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            wait_edges(1);
            if (i == 12) btn = 1'b0;
            case (i)
                5:  chk("fresh_req_before", req_pending, 1'b0);
                6:  begin
                        chk("fresh_req_rise", req_pending, 1'b1);
                        chk("fresh_go_hold6", go, 1'b1);
                    end
                7:  chk("fresh_go_hold7", go, 1'b1);
                8:  begin
                        chk("fresh_go_fall", go, 1'b0);
                        chk("fresh_walk_off", walk, 1'b0);
                    end
                13: begin
                        chk("fresh_walk_before", walk, 1'b0);
                        chk("fresh_req_held", req_pending, 1'b1);
                    end
                14: begin
                        chk("fresh_walk_rise", walk, 1'b1);
                        chk("fresh_req_fall", req_pending, 1'b0);
                    end
                23: begin
                        chk("fresh_walk_last", walk, 1'b1);
                        chk("fresh_go_low_last", go, 1'b0);
                    end
                24: begin
                        chk("fresh_walk_fall", walk, 1'b0);
                        chk("fresh_go_rise", go, 1'b1);
                    end
                default: ;
            endcase
        end
    endtask

    initial begin
        int seg;
        rst = 1'b1;
        btn = 1'b0;

        // Reset state, then idle with no press
        wait_edges(2);
        chk("rst_go", go, 1'b1);
        chk("rst_walk", walk, 1'b0);
        chk("rst_req", req_pending, 1'b0);
        rst = 1'b0;
        wait_edges(30);
        chk("idle_go", go, 1'b1);
        chk("idle_req", req_pending, 1'b0);

        // Press right after reset release
        rst = 1'b1;
        wait_edges(2);
        fresh_press();

        // Short glitches are rejected
        for (int g = 0; g < 5; g++) begin
            btn = 1'b1;
            wait_edges(3);
            btn = 1'b0;
            wait_edges(3);
        end
        wait_edges(6);
        chk("glitch_req", req_pending, 1'b0);
        chk("glitch_go", go, 1'b1);

        // Late press with go_cnt saturated, plus a second press during WALK
        rst = 1'b1;
        wait_edges(1);
        rst = 1'b0;
        wait_edges(100);
        btn = 1'b1;
        for (int i = 0; i <= 22; i++) begin
            wait_edges(1);
            if (i == 7)  btn = 1'b0;
            if (i == 13) btn = 1'b1;
            if (i == 19) btn = 1'b0;
            case (i)
                4:  chk("late_req_before", req_pending, 1'b0);
                5:  begin
                        chk("late_req_rise", req_pending, 1'b1);
                        chk("late_go_hold", go, 1'b1);
                    end
                6:  chk("late_go_fall", go, 1'b0);
                11: chk("late_walk_before", walk, 1'b0);
                12: begin
                        chk("late_walk_rise", walk, 1'b1);
                        chk("late_req_fall", req_pending, 1'b0);
                    end
                20: chk("walk_press_dropped", req_pending, 1'b0);
                21: chk("late_walk_last", walk, 1'b1);
                22: begin
                        chk("late_walk_fall", walk, 1'b0);
                        chk("late_go_rise", go, 1'b1);
                    end
                default: ;
            endcase
        end
        for (int i = 0; i < 50; i++) begin
            wait_edges(1);
            chk("after_walk_go", go, 1'b1);
            chk("after_walk_req", req_pending, 1'b0);
        end

        // Debounced rise landing on the edge that leaves WALK is dropped,
        // and holding the button on into GO raises nothing
        btn = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            wait_edges(1);
            if (i == 7)  btn = 1'b0;
            if (i == 16) btn = 1'b1;
            if (i == 12) chk("edge_walk_rise", walk, 1'b1);
            if (i == 22) begin
                chk("edge_exit_go", go, 1'b1);
                chk("edge_exit_req", req_pending, 1'b0);
            end
            if (i == 32) chk("held_into_go_req", req_pending, 1'b0);
        end
        btn = 1'b0;
        wait_edges(20);

        // Reset pulsed in the 4th WALK cycle, then a full fresh cycle
        btn = 1'b1;
        for (int i = 0; i <= 15; i++) begin
            wait_edges(1);
            if (i == 7) btn = 1'b0;
            if (i == 12) chk("mid_walk_on", walk, 1'b1);
        end
        rst = 1'b1;
        wait_edges(1);
        chk("midrst_walk", walk, 1'b0);
        chk("midrst_go", go, 1'b1);
        chk("midrst_req", req_pending, 1'b0);
        fresh_press();

        // Randomized button activity with occasional resets
        seg = 0;
        for (int n = 0; n < 3000; n++) begin
            if (seg == 0) begin
                btn = 1'($urandom_range(0, 1));
                seg = int'($urandom_range(1, 14));
            end
            seg--;
            rst = ($urandom_range(0, 249) == 0);
            wait_edges(1);
        end
        rst = 1'b0;
        btn = 1'b0;
        wait_edges(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
